inst_fetch: RTL

//  Fetch-side initiator for the synchronous instruction ROM. Holds the PC and drives the ROM byte address.

---
 rtl/inst_fetch.sv | 96 +++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator for a synchronous 1-cycle-latency ROM: PC sequencing,
// byte-swap to MIPS order, valid/ready handoff to decode, redirect squash, sticky fault.
module inst_fetch #(
    parameter int unsigned ADDR_W    = 9,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] LAST_ADDR = 32'd172
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_fault,
    output logic [31:0]       fault_pc
);

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_fetch_pc,  w_fetch_pc_nxt;
    logic        r_req_valid, w_req_valid_nxt;
    logic [31:0] r_req_pc,    w_req_pc_nxt;
    logic [31:0] r_fault_pc,  w_fault_pc_nxt;
    logic        w_hold;
    logic        w_bad_pc;

    // A stalled word is re-read from its own address so rom_data stays stable for decode.
    assign w_hold   = r_req_valid & ~if_ready & ~redirect;
    assign w_bad_pc = (r_fetch_pc[1:0] != 2'b00) || (r_fetch_pc > LAST_ADDR);
    assign rom_addr = w_hold ? r_req_pc[ADDR_W-1:0] : r_fetch_pc[ADDR_W-1:0];

    always_comb begin
        // NOTE: every next-state value starts from its current value so no path infers a latch.
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_req_valid_nxt = r_req_valid;
        w_req_pc_nxt    = r_req_pc;
        w_fault_pc_nxt  = r_fault_pc;
        case (r_state)
            ST_RUN: begin
                if (redirect) begin
                    w_fetch_pc_nxt  = redirect_pc;
                    w_req_valid_nxt = 1'b0;
                end else if (w_hold) begin
                    w_req_valid_nxt = r_req_valid;
                end else if (w_bad_pc) begin
                    w_state_nxt     = ST_FAULT;
                    w_fault_pc_nxt  = r_fetch_pc;
                    w_req_valid_nxt = 1'b0;
                end else begin
                    w_req_valid_nxt = 1'b1;
                    w_req_pc_nxt    = r_fetch_pc;
                    w_fetch_pc_nxt  = r_fetch_pc + 32'd4;
                end
            end
            ST_FAULT: begin
                // Only reset leaves FAULT; redirect and handshake inputs are ignored.
                w_req_valid_nxt = 1'b0;
            end
            default: w_state_nxt = ST_FAULT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_fetch_pc  <= RESET_PC;
            r_req_valid <= 1'b0;
            r_req_pc    <= 32'h0;
            r_fault_pc  <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_fault_pc  <= w_fault_pc_nxt;
        end
    end

    assign if_valid    = r_req_valid;
    assign if_pc       = r_req_pc;
    assign if_inst     = r_req_valid ? {rom_data[7:0], rom_data[15:8], rom_data[23:16], rom_data[31:24]}
                                     : 32'h0;
    assign fetch_fault = (r_state == ST_FAULT);
    assign fault_pc    = r_fault_pc;

endmodule
